// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   funct3_e  - RISC-V load/store width codes
//   state_e   - lsu FSM state encoding
//   size_e    - effective access size after decoding funct3
//   *_W       - lane widths in bits
//   access_size() - maps any funct3 (including reserved/unsupported codes)
//                   to an effective access size.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        FN_B  = 3'b000,
        FN_H  = 3'b001,
        FN_W  = 3'b010,
        FN_BU = 3'b100,
        FN_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // funct3[1] set covers 010/011/110/111: word, including the unsupported
    // codes. Otherwise funct3[0] picks half vs byte, which also folds the
    // unsigned load codes 100/101 (and their store aliases) onto byte/half.
    function automatic size_e access_size(input logic [2:0] funct3);
        if (funct3[1])      return SZ_W;
        else if (funct3[0]) return SZ_H;
        else                return SZ_B;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the lsu.
//   word    in  32  word read from RAM
//   offset  in  2   byte offset (address bits [1:0])
//   funct3  in  3   width/sign code
//   wdata   in  32  right-aligned store data
//   rdata   out 32  extracted and sign/zero-extended load data
//   merged  out 32  word with the store lane replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    size_e       sz;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sext;

    always_comb begin
        sz   = access_size(funct3);
        // funct3[2] marks the unsigned loads; word loads ignore it.
        sext = ~funct3[2];

        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (sz)
            SZ_B:    rdata = {{(WORD_W-BYTE_W){sext & lane_b[7]}}, lane_b};
            SZ_H:    rdata = {{(WORD_W-HALF_W){sext & lane_h[15]}}, lane_h};
            default: rdata = word;
        endcase

        merged = word;
        case (sz)
            SZ_B: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of a single-port word RAM. Sub-word stores
// are done as read-modify-write; loads are sign/zero-extended.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned half/word
// accesses complete with resp_err=1 and no RAM access).
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake: a request transfers on a rising
//                         edge where both are 1; req_ready is 1 only in IDLE
//   req_we/funct3/addr/wdata  request fields, sampled only at acceptance
//   resp_valid/rdata/err  one-cycle completion pulse, no backpressure
//   mem_addr/we/wdata     registered word-aligned RAM controls
//   mem_rdata             combinational RAM read data
// MEM_SIZE must be a power of two (addresses wrap by masking).
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_RESP  = ST_RESP;

    localparam logic [29:0] WORD_MASK = 30'(MEM_SIZE - 1);

    logic [1:0]  state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;

    logic [29:0] word_idx;
    logic        misaligned;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state == S_IDLE);
    assign word_idx  = req_addr[31:2] & WORD_MASK;

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (access_size(req_funct3))
            SZ_H:    misaligned = req_addr[0];
            SZ_W:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .wdata  (wdata_q),
        .rdata  (load_data),
        .merged (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            off_q      <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        if (misaligned) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            mem_addr <= {word_idx, 2'b00};
                            if (!req_we || access_size(req_funct3) != SZ_W) begin
                                state <= S_READ;
                            end else begin
                                // Full-word store skips the read entirely.
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                                state     <= S_WRITE;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (we_q) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= merged_word;
                        state     <= S_WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                default: begin
                    // Clear the response so rdata/err are only non-zero
                    // alongside resp_valid.
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a behavioural word RAM.
module tb_lsu;

    localparam int MEM_SIZE = 128;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MCHK = 1'b1;
`else
    localparam bit MCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [MEM_SIZE];

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    lsu #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // RAM model: out-of-range or unaligned addresses read a marker value.
    assign mem_rdata = (mem_addr[31:9] == 23'd0 && mem_addr[1:0] == 2'b00)
                       ? ram[mem_addr[8:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we && mem_addr[31:9] == 23'd0 && mem_addr[1:0] == 2'b00)
            ram[mem_addr[8:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver: one request, then monitor until resp_valid (bounded)
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_wr, input int exp_rd);
        int lat = 0;
        int wr = 0;
        int rd = 0;
        int busy_hi = 0;
        logic [31:0] rdata = '0;
        logic err = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request fields; the unit must not look at them now.
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (req_ready) busy_hi++;
            if (mem_we) wr++;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
            end else if (!mem_we) begin
                rd++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " write_cycles"}, 32'(wr), 32'(exp_wr));
        check({tag, " read_cycles"}, 32'(rd), 32'(exp_rd));
        check({tag, " busy"}, 32'(busy_hi), 32'd0);
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] rsp [4];
        int rsp_c [4];
        int nresp;

        for (int i = 0; i < MEM_SIZE; i++) ram[i] = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        // word store / load
        xact("sw0", 1'b1, 3'b010, 32'h0, 32'h1234_5678, 2, 32'h0, 1'b0, 1, 0);
        check("sw0 ram", ram[0], 32'h1234_5678);
        xact("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h1234_5678, 1'b0, 0, 1);

        // byte RMW; upper wdata bits must not leak into the word
        xact("sb1", 1'b1, 3'b000, 32'h1, 32'hFFFF_FFAB, 3, 32'h0, 1'b0, 1, 1);
        xact("lw0b", 1'b0, 3'b010, 32'h0, 32'h0, 2, 32'h1234_AB78, 1'b0, 0, 1);

        // extension over word 1 = 0x8000FF7F
        xact("sw4", 1'b1, 3'b010, 32'h4, 32'h8000_FF7F, 2, 32'h0, 1'b0, 1, 0);
        xact("lb4", 1'b0, 3'b000, 32'h4, 32'h0, 2, 32'h0000_007F, 1'b0, 0, 1);
        xact("lb5", 1'b0, 3'b000, 32'h5, 32'h0, 2, 32'hFFFF_FFFF, 1'b0, 0, 1);
        xact("lbu5", 1'b0, 3'b100, 32'h5, 32'h0, 2, 32'h0000_00FF, 1'b0, 0, 1);
        xact("lh6", 1'b0, 3'b001, 32'h6, 32'h0, 2, 32'hFFFF_8000, 1'b0, 0, 1);
        xact("lhu6", 1'b0, 3'b101, 32'h6, 32'h0, 2, 32'h0000_8000, 1'b0, 0, 1);

        // upper-half store, reserved-code byte store, unsupported-code load
        xact("sh6", 1'b1, 3'b001, 32'h6, 32'hAAAA_1234, 3, 32'h0, 1'b0, 1, 1);
        xact("sb7r", 1'b1, 3'b100, 32'h7, 32'h0000_0156, 3, 32'h0, 1'b0, 1, 1);
        xact("lw4x", 1'b0, 3'b011, 32'h4, 32'h0, 2, 32'h5634_FF7F, 1'b0, 0, 1);

        // word 2 and address wrap (0x208 aliases 0x008)
        xact("sw8", 1'b1, 3'b010, 32'h8, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1, 0);
        xact("lwwrap", 1'b0, 3'b010, 32'h208, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 0, 1);

        // misaligned accesses on word 0 (= 0x1234AB78)
        if (MCHK) begin
            xact("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 1'b1, 0, 0);
            xact("sh1", 1'b1, 3'b001, 32'h1, 32'h1111, 1, 32'h0, 1'b1, 0, 0);
            w0 = 32'h1234_AB78;
        end else begin
            xact("lw2", 1'b0, 3'b010, 32'h2, 32'h0, 2, 32'h1234_AB78, 1'b0, 0, 1);
            xact("sh1", 1'b1, 3'b001, 32'h1, 32'h1111, 3, 32'h0, 1'b0, 1, 1);
            w0 = 32'h1234_1111;
        end
        xact("lw0c", 1'b0, 3'b010, 32'h0, 32'h0, 2, w0, 1'b0, 0, 1);

        // reset during the READ cycle of SB 0x3
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h3; req_wdata = 32'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw read ready", 32'(req_ready), 32'd0);
        check("rmw read we", 32'(mem_we), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("midrst ready", 32'(req_ready), 32'd1);
        check("midrst mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst ram", ram[0], w0);
        xact("lw0d", 1'b0, 3'b010, 32'h0, 32'h0, 2, w0, 1'b0, 0, 1);

        // back-to-back loads with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
        nresp = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3) check("b2b idle ready", 32'(req_ready), 32'd1);
            if (resp_valid && nresp < 4) begin
                rsp[nresp]   = resp_rdata;
                rsp_c[nresp] = c;
                nresp++;
                if (nresp == 1) req_addr = 32'h8;
                if (nresp == 2) req_valid = 1'b0;
            end
        end
        check("b2b count", 32'(nresp), 32'd2);
        check("b2b first data", rsp[0], 32'h5634_FF7F);
        check("b2b first cycle", 32'(rsp_c[0]), 32'd2);
        check("b2b second data", rsp[1], 32'hCAFE_F00D);
        check("b2b second cycle", 32'(rsp_c[1]), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
